// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader
// feeding the core's RAM programming port.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    RUN,
    HALTED,
    ERROR
  } state_t;

  localparam logic MODE_PROG = 1'b1;
  localparam logic MODE_RUN  = 1'b0;

  localparam int RUNCNT_W = 16;

  function automatic logic [RUNCNT_W-1:0] sat_inc(
    input logic [RUNCNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/prog_shadow.sv
// Shadow copy of the loaded program, read back
// against RAM during verify.
module prog_shadow
  import loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Streams a program into CPU RAM, optionally verifies it,
// then runs the core until halt and counts run cycles.
module prog_loader
  import loader_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int VERIFY_EN = 1,
  parameter int RD_LAT    = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                halt,
  input  logic [DATA_W-1:0]   ramload,
  output logic                mode,
  output logic                WEN,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   instr,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [RUNCNT_W-1:0] run_cycles
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  state_t state, state_n;

  logic [CNT_W-1:0]    count, count_n;
  logic                mode_n, wen_n, rdy_n;
  logic                done_n, err_n;
  logic [ADDR_W-1:0]   addr_n, err_addr_n;
  logic [DATA_W-1:0]   instr_n;
  logic [RUNCNT_W-1:0] runc_n;
  logic                iss, iss_n;

  // Tracks which verify address each ramload sample belongs to.
  logic [RD_LAT-1:0]   dly_v;
  logic [ADDR_W-1:0]   dly_a [RD_LAT];
  logic [ADDR_W-1:0]   chk_a;
  logic                chk_v;
  logic [DATA_W-1:0]   shadow;
  logic                hs;

  assign hs    = in_valid & in_ready;
  assign chk_v = dly_v[RD_LAT-1];
  assign chk_a = dly_a[RD_LAT-1];

  prog_shadow #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_shadow (
    .clk  (CLK),
    .we   (hs),
    .waddr(count[ADDR_W-1:0]),
    .wdata(in_data),
    .raddr(chk_a),
    .rdata(shadow)
  );

  always_comb begin
    state_n    = state;
    count_n    = count;
    mode_n     = mode;
    wen_n      = 1'b0;
    addr_n     = addr;
    instr_n    = instr;
    rdy_n      = 1'b0;
    done_n     = done;
    err_n      = err;
    err_addr_n = err_addr;
    runc_n     = run_cycles;
    iss_n      = 1'b0;
    unique case (state)
      IDLE: begin
        mode_n = MODE_PROG;
        if (start) begin
          state_n = LOAD;
          count_n = '0;
          rdy_n   = 1'b1;
        end
      end
      LOAD: begin
        mode_n = MODE_PROG;
        if (hs) begin
          wen_n   = 1'b1;
          addr_n  = count[ADDR_W-1:0];
          instr_n = in_data;
          count_n = count + 1'b1;
        end
        rdy_n = (count_n < DEPTH_C);
        if (WEN && count == DEPTH_C) begin
          rdy_n  = 1'b0;
          addr_n = '0;
          if (VERIFY_EN != 0) begin
            state_n = VERIFY;
            iss_n   = 1'b1;
            count_n = CNT_W'(1);
          end else begin
            state_n = RUN;
            mode_n  = MODE_RUN;
            runc_n  = '0;
          end
        end
      end
      VERIFY: begin
        mode_n = MODE_PROG;
        if (count < DEPTH_C) begin
          addr_n  = count[ADDR_W-1:0];
          iss_n   = 1'b1;
          count_n = count + 1'b1;
        end
        if (chk_v) begin
          if (ramload != shadow) begin
            state_n    = ERROR;
            err_n      = 1'b1;
            err_addr_n = chk_a;
            iss_n      = 1'b0;
          end else if (chk_a == LAST_A) begin
            state_n = RUN;
            mode_n  = MODE_RUN;
            addr_n  = '0;
            runc_n  = '0;
          end
        end
      end
      RUN: begin
        mode_n = MODE_RUN;
        addr_n = '0;
        if (halt) begin
          state_n = HALTED;
          done_n  = 1'b1;
        end else begin
          runc_n = sat_inc(run_cycles);
        end
      end
      HALTED: begin
        if (start) begin
          state_n = LOAD;
          mode_n  = MODE_PROG;
          done_n  = 1'b0;
          count_n = '0;
          rdy_n   = 1'b1;
        end
      end
      ERROR: begin
        mode_n = MODE_PROG;
        if (start) begin
          state_n = LOAD;
          err_n   = 1'b0;
          count_n = '0;
          rdy_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      count      <= '0;
      mode       <= MODE_PROG;
      WEN        <= 1'b0;
      addr       <= '0;
      instr      <= '0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_addr   <= '0;
      run_cycles <= '0;
      iss        <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      mode       <= mode_n;
      WEN        <= wen_n;
      addr       <= addr_n;
      instr      <= instr_n;
      in_ready   <= rdy_n;
      done       <= done_n;
      err        <= err_n;
      err_addr   <= err_addr_n;
      run_cycles <= runc_n;
      iss        <= iss_n;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dly_v <= '0;
      for (int i = 0; i < RD_LAT; i++) dly_a[i] <= '0;
    end else begin
      dly_v[0] <= (state == VERIFY) & iss;
      dly_a[0] <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        dly_v[i] <= (state == VERIFY) & dly_v[i-1];
        dly_a[i] <= dly_a[i-1];
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the CPU core. Drives the core's mode, instr, addr and WEN inputs.
- Accepts a 16-byte program over a valid/ready byte stream and writes it into CPU RAM in program mode.
- Optionally reads the program back through ramload to verify it, then releases the CPU into run mode.
- Monitors halt and reports completion plus a run-cycle count.

Parameters:
- DEPTH, 16, number of program bytes per load; must equal 2**ADDR_W.
- ADDR_W, 4, RAM address width.
- DATA_W, 8, instruction/data byte width.
- VERIFY_EN, 1, 1 = read back and compare after load; 0 = go straight to run.
- RD_LAT, 1, cycles from addr driven to ramload valid during verify.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load.
- in_valid  input  1  byte available on in_data.
- in_data  input  DATA_W  program byte.
- in_ready  output  1  loader accepts a byte this cycle.
- halt  input  1  from CPU core.
- ramload  input  DATA_W  RAM read data from CPU core.
- mode  output  1  to CPU; 1 = program mode, 0 = run mode.
- WEN  output  1  to CPU; RAM write enable.
- addr  output  ADDR_W  to CPU; RAM address.
- instr  output  DATA_W  to CPU; RAM write data.
- done  output  1  CPU has halted after a run.
- err  output  1  verify mismatch.
- err_addr  output  ADDR_W  first mismatching address.
- run_cycles  output  16  cycles spent in RUN; saturates at 16'hFFFF.

Behaviour:
- Reset values: mode=1, WEN=0, addr=0, instr=0, in_ready=0, done=0, err=0, err_addr=0, run_cycles=0, state IDLE, byte count 0. All outputs are registered.
- Reset mid-operation returns everything to reset values immediately; RAM contents after that are undefined.
- IDLE
  - mode=1.
  - start -> LOAD; count=0.
- LOAD
  - in_ready=1 while count<DEPTH.
  - Handshake (in_valid & in_ready) at cycle N: in cycle N+1, WEN=1, addr=count, instr=in_data; count increments; the byte is also stored in the shadow buffer.
  - WEN is high for exactly one cycle per accepted byte. Back-to-back handshakes give back-to-back WEN cycles.
  - After the DEPTH-th handshake, in_ready drops in the next cycle.
  - After the final WEN cycle: -> VERIFY if VERIFY_EN, else -> RUN.
  - start during LOAD is ignored. in_valid while in_ready=0 is ignored (byte not consumed).
- VERIFY
  - WEN=0, mode=1.
  - addr steps 0..DEPTH-1, one per cycle.
  - ramload is compared with the shadow byte RD_LAT cycles after each addr.
  - First mismatch -> ERROR: err=1, err_addr=mismatching address; remaining compares are abandoned.
  - All DEPTH compares equal -> RUN.
- RUN
  - mode=0, WEN=0, addr=0.
  - run_cycles is cleared on entry and increments each RUN cycle, saturating.
  - halt=1 -> HALTED. halt is sampled only in RUN; halt in any other state is ignored.
- HALTED
  - done=1, mode stays 0, run_cycles held.
  - start -> LOAD: mode=1, done=0, count=0.
- ERROR
  - err=1, mode=1.
  - start -> LOAD, clearing err.
- Address wrap: count is ADDR_W+1 bits so that DEPTH is detectable; addr uses the low ADDR_W bits.
- start and halt in the same cycle while in RUN: halt wins; start is ignored.

Decomposition:
- loader_pkg
  - state enum: IDLE, LOAD, VERIFY, RUN, HALTED, ERROR.
  - MODE_PROG=1'b1, MODE_RUN=1'b0.
  - run-cycle counter width constant.
- Sub-module prog_shadow
  - DEPTH x DATA_W register file.
  - Synchronous write at the handshake.
  - Combinational read indexed by the delayed verify address.
- FSM, counter and verify pipeline live in prog_loader.

Test Plan:
- Basic load and verify: reset, start, stream bytes 8'h10..8'h1F with in_valid held high -> 16 consecutive WEN pulses with addr 0..15, instr 10..1F; RAM model echoes the bytes; mode falls to 0 after verify completes.
- Stalled producer: insert random 0-3 cycle gaps in in_valid -> WEN pulses only on accepted bytes, addr/instr pairing unchanged, no duplicate writes.
- Corrupted readback: RAM model corrupts addr 7 (returns 8'hFF) -> err=1, err_addr=7, mode stays 1, never enters RUN; a subsequent start reloads and clears err.
- Run and halt: after a clean load, assert halt 25 cycles after mode=0 -> done=1, run_cycles=25, halt pulses before RUN have no effect.
- Reset mid-load: deassert nRST after 5 bytes -> all outputs return to reset values asynchronously; after reset, a fresh start loads from addr 0.
- VERIFY_EN=0 build: after the 16th WEN pulse, mode=0 on the following cycle with no verify addr sweep.
